// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, sync-stage payload type and address packing.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_FP         = 16;
    localparam int unsigned H_SYNC       = 96;
    localparam int unsigned H_BP         = 48;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_FP         = 10;
    localparam int unsigned V_SYNC       = 2;
    localparam int unsigned V_BP         = 33;
    localparam int unsigned DATA_LATENCY = 2;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 2 * CNT_W;
    localparam int unsigned RGB_W  = 24;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_t;

    localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [CNT_W-1:0] v,
                                                    input logic [CNT_W-1:0] h);
        return {v, h};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register aligning {hsync, vsync, active} with the returning pixel data.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_hsync,
    input  logic i_vsync,
    input  logic i_active,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_active
);

    sync_t r_pipe [DEPTH];

    // Every stage clears to the idle sync state so a reset never stretches a pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= SYNC_RST;
            end
        end else begin
            r_pipe[0] <= '{hsync: i_hsync, vsync: i_vsync, active: i_active};
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_hsync  = r_pipe[DEPTH-1].hsync;
    assign o_vsync  = r_pipe[DEPTH-1].vsync;
    assign o_active = r_pipe[DEPTH-1].active;

endmodule

// File: rtl/vga_request_gen.sv
// VGA raster generator: registered request/address stage and a latency-matched DAC stage.
module vga_request_gen #(
    parameter int unsigned H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP         = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC       = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP         = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP         = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC       = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP         = vga_timing_pkg::V_BP,
    parameter int unsigned DATA_LATENCY = vga_timing_pkg::DATA_LATENCY
) (
    input  logic        iVgaClk,
    input  logic        reset,
    input  logic [23:0] iVideo8bRgb,
    output logic        oVgaHRequest,
    output logic        oVgaVRequest,
    output logic        oVgaRequest,
    output logic [19:0] oPixelAddress,
    output logic        oFrameStart,
    output logic [23:0] oVgaRgb,
    output logic        oHsync,
    output logic        oVsync,
    output logic        oBlankN
);
    import vga_timing_pkg::*;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  r_h_count;
    logic [9:0]  r_v_count;
    logic        w_h_wrap;
    logic        w_h_req;
    logic        w_v_req;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_frame_start;

    logic        r_h_req;
    logic        r_v_req;
    logic        r_req;
    logic [19:0] r_addr;
    logic        r_frame_start;
    logic        r_hsync;
    logic        r_vsync;
    logic [23:0] r_pixel;

    logic        w_dly_hsync;
    logic        w_dly_vsync;
    logic        w_dly_active;

    assign w_h_wrap      = (r_h_count == H_LAST);
    assign w_h_req       = (r_h_count < H_ACT);
    assign w_v_req       = (r_v_count < V_ACT);
    assign w_hsync       = !((r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST));
    assign w_vsync       = !((r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST));
    assign w_frame_start = (r_h_count == '0) && (r_v_count == '0);

    // Raster counters; both wrap on an explicit compare.
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else begin
            r_h_count <= w_h_wrap ? '0 : r_h_count + 10'd1;
            if (w_h_wrap) begin
                r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
            end
        end
    end

    // Request stage: registered decode of the current counter state.
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            r_h_req       <= 1'b0;
            r_v_req       <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_frame_start <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
        end else begin
            r_h_req       <= w_h_req;
            r_v_req       <= w_v_req;
            r_req         <= w_h_req & w_v_req;
            r_addr        <= pack_addr(r_v_count, r_h_count);
            r_frame_start <= w_frame_start;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
        end
    end

    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            r_pixel <= '0;
        end else begin
            r_pixel <= iVideo8bRgb;
        end
    end

    vga_sync_delay #(
        .DEPTH (DATA_LATENCY + 1)
    ) u_sync_delay (
        .i_clk    (iVgaClk),
        .i_reset  (reset),
        .i_hsync  (r_hsync),
        .i_vsync  (r_vsync),
        .i_active (r_req),
        .o_hsync  (w_dly_hsync),
        .o_vsync  (w_dly_vsync),
        .o_active (w_dly_active)
    );

    assign oVgaHRequest  = r_h_req;
    assign oVgaVRequest  = r_v_req;
    assign oVgaRequest   = r_req;
    assign oPixelAddress = r_addr;
    assign oFrameStart   = r_frame_start;
    assign oVgaRgb       = w_dly_active ? r_pixel : '0;
    assign oHsync        = w_dly_hsync;
    assign oVsync        = w_dly_vsync;
    assign oBlankN       = w_dly_active;

endmodule
